// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The slave side is the adder; the master side is whoever produces operands
// and consumes results.
interface pipelined_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor.
// Each stage resolves one CHUNK-bit slice and registers the carry into the
// next stage; the operands and the partially built sum travel alongside the
// beat. The whole pipeline freezes while a result is waiting on out_ready.
module pipelined_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_adder_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
  end

  // One slice of ripple addition: CHUNK result bits plus the carry out.
  function automatic logic [CHUNK:0] add_slice(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  // Two's complement overflow: carry into the MSB differs from carry out.
  // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb,
                                      input logic c_out);
    return (a_msb ^ b_msb ^ s_msb) ^ c_out;
  endfunction

  // Per-stage registers; index k holds the beat that has resolved slices 0..k.
  logic             vld_p [STAGES];
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];   // b already inverted for subtraction
  logic [WIDTH-1:0] s_p   [STAGES];
  logic             c_p   [STAGES];
  logic             ovf_p;

  // Inputs seen by each stage (stage 0 from the bus, others from stage k-1).
  logic             vld_src [STAGES];
  logic [WIDTH-1:0] a_src   [STAGES];
  logic [WIDTH-1:0] b_src   [STAGES];
  logic [WIDTH-1:0] s_src   [STAGES];
  logic             c_src   [STAGES];

  logic [CHUNK:0]   r_c     [STAGES];
  logic [WIDTH-1:0] s_nxt   [STAGES];
  logic             c_nxt   [STAGES];
  logic             ovf_nxt;

  logic             adv;

  // A result held for the consumer stalls every stage, including stage 0.
  assign adv          = ~(vld_p[LAST] & ~bus.out_ready);
  assign bus.in_ready = adv;

  // Route stage inputs and resolve this stage's slice.
  always_comb begin
    vld_src[0] = bus.in_valid;
    a_src[0]   = bus.a;
    b_src[0]   = bus.sub ? ~bus.b : bus.b;
    s_src[0]   = '0;
    c_src[0]   = bus.cin ^ bus.sub;   // subtract uses ~cin as the carry-in
    for (int k = 1; k < STAGES; k++) begin
      vld_src[k] = vld_p[k-1];
      a_src[k]   = a_p[k-1];
      b_src[k]   = b_p[k-1];
      s_src[k]   = s_p[k-1];
      c_src[k]   = c_p[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      r_c[k]   = add_slice(a_src[k][k*CHUNK +: CHUNK],
                           b_src[k][k*CHUNK +: CHUNK], c_src[k]);
      s_nxt[k] = s_src[k];
      s_nxt[k][k*CHUNK +: CHUNK] = r_c[k][CHUNK-1:0];
      c_nxt[k] = r_c[k][CHUNK];
    end
    ovf_nxt = signed_ovf(a_src[LAST][WIDTH-1], b_src[LAST][WIDTH-1],
                         s_nxt[LAST][WIDTH-1], c_nxt[LAST]);
  end

  // Stage boundary registers; data only loads behind a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= 1'b0;
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        s_p[k]   <= '0;
        c_p[k]   <= 1'b0;
      end
      ovf_p <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= vld_src[k];
        if (vld_src[k]) begin
          a_p[k] <= a_src[k];
          b_p[k] <= b_src[k];
          s_p[k] <= s_nxt[k];
          c_p[k] <= c_nxt[k];
        end
      end
      if (vld_src[LAST]) begin
        ovf_p <= ovf_nxt;
      end
    end
  end

  // Final stage registers drive the result directly.
  assign bus.out_valid = vld_p[LAST];
  assign bus.sum       = s_p[LAST];
  assign bus.cout      = c_p[LAST];
  assign bus.ovf       = ovf_p;
endmodule
